// File: rtl/riscv_pkg.sv
// Types and constants shared by the RV32I pipeline register chain and the hazard unit.
// Holds the bubble instruction, base opcodes and the per-stage payload struct.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] ArithmeticR = 7'b0110011;
    localparam logic [6:0] ArithmeticI = 7'b0010011;
    localparam logic [6:0] MemoryLoad  = 7'b0000011;
    localparam logic [6:0] MemoryStore = 7'b0100011;
    localparam logic [6:0] Branch      = 7'b1100011;
    localparam logic [6:0] Jal         = 7'b1101111;
    localparam logic [6:0] Jalr        = 7'b1100111;
    localparam logic [6:0] Lui         = 7'b0110111;
    localparam logic [6:0] Auipc       = 7'b0010111;
    localparam logic [6:0] System      = 7'b1110011;

    typedef struct packed {
        logic [31:0] is;
        logic [31:0] pc;
        logic        vld;
    } stage_t;

    localparam stage_t BUBBLE = '{is: NOP, pc: 32'h0, vld: 1'b0};

    function automatic logic [6:0] opcode_of(input logic [31:0] ins);
        return ins[6:0];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register (instruction, PC, valid); one-cycle latency.
// clr loads a bubble and overrides en; en=0 holds the stage.
module pipe_stage_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rstn,
    input  logic   en,
    input  logic   clr,
    input  stage_t d,
    output stage_t q
);

    stage_t r_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q <= BUBBLE;
        end else if (clr) begin
            r_q <= BUBBLE;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipe_is_chain.sv
// PC and IF/ID..MEM/WB instruction chain driven by the hazard unit's stall/flush controls; all outputs registered.
// Optional performance counters (stalls, flushes, retirements) are built when PIPE_PERF_CNT_EN is defined.
module pipe_is_chain
    import riscv_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pc_en,
    input  logic        if_id_en,
    input  logic        if_id_clear,
    input  logic        id_ex_clear,
    input  logic [31:0] npc,
    input  logic [31:0] if_is,
    output logic [31:0] pc,
    output logic [31:0] id_is,
    output logic [31:0] ex_is,
    output logic [31:0] mem_is,
    output logic [31:0] wb_is,
    output logic [31:0] id_pc,
    output logic [31:0] ex_pc,
    output logic [31:0] mem_pc,
    output logic [31:0] wb_pc,
    output logic        id_vld,
    output logic        ex_vld,
    output logic        mem_vld,
    output logic        wb_vld,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] retire_cnt,
`endif
    output logic        wb_retire
);

    logic [31:0] r_pc;
    stage_t      w_fetch;
    stage_t      w_id;
    stage_t      w_ex;
    stage_t      w_mem;
    stage_t      w_wb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= PC_RESET;
        end else if (pc_en) begin
            r_pc <= npc;
        end
    end

    assign w_fetch = '{is: if_is, pc: r_pc, vld: 1'b1};

    pipe_stage_reg u_if_id (
        .clk (clk), .rstn(rstn), .en(if_id_en), .clr(if_id_clear), .d(w_fetch), .q(w_id)
    );

    // ID/EX has no hold: a stall must always be paired with id_ex_clear.
    pipe_stage_reg u_id_ex (
        .clk (clk), .rstn(rstn), .en(1'b1), .clr(id_ex_clear), .d(w_id), .q(w_ex)
    );

    pipe_stage_reg u_ex_mem (
        .clk (clk), .rstn(rstn), .en(1'b1), .clr(1'b0), .d(w_ex), .q(w_mem)
    );

    pipe_stage_reg u_mem_wb (
        .clk (clk), .rstn(rstn), .en(1'b1), .clr(1'b0), .d(w_mem), .q(w_wb)
    );

    assign pc        = r_pc;
    assign id_is     = w_id.is;
    assign id_pc     = w_id.pc;
    assign id_vld    = w_id.vld;
    assign ex_is     = w_ex.is;
    assign ex_pc     = w_ex.pc;
    assign ex_vld    = w_ex.vld;
    assign mem_is    = w_mem.is;
    assign mem_pc    = w_mem.pc;
    assign mem_vld   = w_mem.vld;
    assign wb_is     = w_wb.is;
    assign wb_pc     = w_wb.pc;
    assign wb_vld    = w_wb.vld;
    assign wb_retire = w_wb.vld;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (!pc_en)                r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (id_ex_clear && pc_en)  r_flush_cnt  <= r_flush_cnt + 32'd1;
            if (w_wb.vld)              r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign retire_cnt = r_retire_cnt;
`endif

    // Holding the PC without bubbling EX would duplicate the ID instruction.
    a_stall_needs_bubble: assert property (@(posedge clk) disable iff (!rstn) pc_en || id_ex_clear);

endmodule

// File: tb/tb_pipe_is_chain.sv
module tb_pipe_is_chain;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
    localparam logic [31:0] TB_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pc_en, if_id_en, if_id_clear, id_ex_clear;
    logic [31:0] npc, if_is;
    logic [31:0] pc, id_is, ex_is, mem_is, wb_is, id_pc, ex_pc, mem_pc, wb_pc;
    logic        id_vld, ex_vld, mem_vld, wb_vld, wb_retire;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, retire_cnt;
`endif

    pipe_is_chain #(.PC_RESET(PC_RST)) dut (
        .clk(clk), .rstn(rstn), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear), .npc(npc), .if_is(if_is),
        .pc(pc), .id_is(id_is), .ex_is(ex_is), .mem_is(mem_is), .wb_is(wb_is),
        .id_pc(id_pc), .ex_pc(ex_pc), .mem_pc(mem_pc), .wb_pc(wb_pc),
        .id_vld(id_vld), .ex_vld(ex_vld), .mem_vld(mem_vld), .wb_vld(wb_vld),
`ifdef PIPE_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt),
`endif
        .wb_retire(wb_retire)
    );

    always #5 clk = ~clk;

    // Reference model: the pipeline as an ordered list of slots ID, EX, MEM, WB.
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] addr;
        logic        real_ins;
    } slot_t;

    localparam slot_t EMPTY = '{ins: TB_NOP, addr: 32'h0, real_ins: 1'b0};

    slot_t       m_slot [4];
    logic [31:0] m_pc;
    logic [31:0] m_stalls, m_flushes, m_retires;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[31:16] ^ 16'h1234, a[15:0]} ^ 32'h0000_0033;
    endfunction

    function automatic void model_reset();
        m_pc = PC_RST;
        for (int i = 0; i < 4; i++) m_slot[i] = EMPTY;
        m_stalls = 0; m_flushes = 0; m_retires = 0;
    endfunction

    function automatic void model_clock();
        slot_t nxt [4];
        if (m_slot[3].real_ins) m_retires = m_retires + 1;
        if (!pc_en) m_stalls = m_stalls + 1;
        if (pc_en && id_ex_clear) m_flushes = m_flushes + 1;
        if (if_id_clear)   nxt[0] = EMPTY;
        else if (if_id_en) nxt[0] = '{ins: if_is, addr: m_pc, real_ins: 1'b1};
        else               nxt[0] = m_slot[0];
        nxt[1] = id_ex_clear ? EMPTY : m_slot[0];
        nxt[2] = m_slot[1];
        nxt[3] = m_slot[2];
        for (int i = 0; i < 4; i++) m_slot[i] = nxt[i];
        if (pc_en) m_pc = npc;
    endfunction

    function automatic logic [292:0] model_vec();
        return {m_pc, m_slot[0], m_slot[1], m_slot[2], m_slot[3], m_slot[3].real_ins};
    endfunction

    function automatic logic [292:0] dut_vec();
        return {pc, id_is, id_pc, id_vld, ex_is, ex_pc, ex_vld, mem_is, mem_pc, mem_vld,
                wb_is, wb_pc, wb_vld, wb_retire};
    endfunction

    task automatic set_ctl(input logic pe, input logic ie, input logic ic, input logic xc);
        pc_en = pe; if_id_en = ie; if_id_clear = ic; id_ex_clear = xc;
    endtask

    task automatic step();
        if_is = imem(m_pc);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        npc  = PC_RST;
        rstn = 1'b0;
        model_reset();
        #3;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] a_is [4];
        logic [31:0] a_pc [4];
        logic        a_v  [4];
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        npc = 32'h0000_0100;
        if_is = 32'hDEAD_BEEF;
        rstn = 1'b0;
        model_reset();
        #1;
        repeat (2) @(posedge clk);
        #1;
        a_is = '{id_is, ex_is, mem_is, wb_is};
        a_pc = '{id_pc, ex_pc, mem_pc, wb_pc};
        a_v  = '{id_vld, ex_vld, mem_vld, wb_vld};
        n_vec++;
        if (pc !== PC_RST) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, PC_RST); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (a_is[i] !== TB_NOP || a_pc[i] !== 32'h0 || a_v[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_stage%0d got is=%h pc=%h vld=%b want is=%h pc=0 vld=0",
                         i, a_is[i], a_pc[i], a_v[i], TB_NOP);
            end
        end
        n_vec++;
        if (wb_retire !== 1'b0) begin n_err++; $display("FAIL reset_retire got %b want 0", wb_retire); end
`ifdef PIPE_PERF_CNT_EN
        n_vec++;
        if ({stall_cnt, flush_cnt, retire_cnt} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_cnt got %h %h %h want 0 0 0", stall_cnt, flush_cnt, retire_cnt);
        end
`endif
        rstn = 1'b1;
    endtask

    task automatic test_straight_line();
        int pulses = 0;
        int first = 0;
        int last = 0;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            if (k <= 3) set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
            else        set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
            npc = m_pc + 32'd4;
            step();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL straight_k%0d got %h want %h", k, dut_vec(), model_vec());
            end
            if (k == 4) begin
                n_vec++;
                if (wb_is !== imem(32'h0) || wb_pc !== 32'h0) begin
                    n_err++; $display("FAIL straight_wb_A got %h@%h want %h@0", wb_is, wb_pc, imem(32'h0));
                end
            end
            if (wb_retire === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
                last = k;
            end
        end
        n_vec++;
        if (pulses != 3 || first != 4 || last != 6) begin
            n_err++; $display("FAIL straight_retire got n=%0d first=%0d last=%0d want 3/4/6", pulses, first, last);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) begin npc = m_pc + 32'd4; step(); end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        npc = 32'h0000_0777;
        step();
        n_vec++;
        if (pc !== 32'h8 || id_is !== imem(32'h4) || ex_is !== TB_NOP || ex_vld !== 1'b0) begin
            n_err++;
            $display("FAIL load_use got pc=%h id=%h ex=%h ex_vld=%b want pc=8 id=%h ex=%h ex_vld=0",
                     pc, id_is, ex_is, ex_vld, imem(32'h4), TB_NOP);
        end
`ifdef PIPE_PERF_CNT_EN
        n_vec++;
        if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
`endif
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) begin npc = m_pc + 32'd4; step(); end
        set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
        npc = 32'h0000_0040;
        step();
        n_vec++;
        if (pc !== 32'h40 || id_is !== TB_NOP || ex_is !== TB_NOP || mem_is !== imem(32'h4)) begin
            n_err++;
            $display("FAIL branch_flush got pc=%h id=%h ex=%h mem=%h want 40/%h/%h/%h",
                     pc, id_is, ex_is, mem_is, TB_NOP, TB_NOP, imem(32'h4));
        end
`ifdef PIPE_PERF_CNT_EN
        n_vec++;
        if (flush_cnt !== 32'd1) begin n_err++; $display("FAIL branch_flush_cnt got %0d want 1", flush_cnt); end
`endif
    endtask

    task automatic test_mid_stall_reset();
        do_reset();
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) begin npc = m_pc + 32'd4; step(); end
        set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (dut_vec() !== model_vec()) begin
            n_err++; $display("FAIL mid_stall_reset got %h want %h", dut_vec(), model_vec());
        end
`ifdef PIPE_PERF_CNT_EN
        n_vec++;
        if ({stall_cnt, flush_cnt, retire_cnt} !== 96'h0) begin
            n_err++; $display("FAIL mid_stall_reset_cnt got %h %h %h want 0", stall_cnt, flush_cnt, retire_cnt);
        end
`endif
        rstn = 1'b1;
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            npc = m_pc + 32'd4;
            step();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL refill_k%0d got %h want %h", k, dut_vec(), model_vec());
            end
        end
        n_vec++;
        if (wb_pc !== PC_RST || wb_is !== imem(PC_RST) || wb_vld !== 1'b1) begin
            n_err++; $display("FAIL refill_wb got %h@%h vld=%b want %h@%h vld=1", wb_is, wb_pc, wb_vld, imem(PC_RST), PC_RST);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                5, 6:    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
                7:       set_ctl(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
                8:       set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
                9:       set_ctl(1'b1, 1'b1, 1'b1, 1'b0);
                default: set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
            endcase
            npc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
            step();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
                n_err++; $display("FAIL random_k%0d got %h want %h", k, dut_vec(), model_vec());
            end
`ifdef PIPE_PERF_CNT_EN
            n_vec++;
            if ({stall_cnt, flush_cnt, retire_cnt} !== {m_stalls, m_flushes, m_retires}) begin
                n_err++;
                $display("FAIL random_cnt_k%0d got %0d/%0d/%0d want %0d/%0d/%0d", k,
                         stall_cnt, flush_cnt, retire_cnt, m_stalls, m_flushes, m_retires);
            end
`endif
        end
    endtask

    task automatic test_retire_count();
        string sched = "FFFSFFFSFFFFDDDDDD";
        int pulses = 0;
        do_reset();
        for (int k = 0; k < sched.len(); k++) begin
            case (sched[k])
                "F":     set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
                "S":     set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
                default: set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
            endcase
            npc = m_pc + 32'd4;
            step();
            if (wb_retire === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 10) begin n_err++; $display("FAIL retire_pulses got %0d want 10", pulses); end
`ifdef PIPE_PERF_CNT_EN
        n_vec++;
        if (retire_cnt !== 32'd10 || stall_cnt !== 32'd2) begin
            n_err++; $display("FAIL retire_cnt got ret=%0d stall=%0d want 10/2", retire_cnt, stall_cnt);
        end
`endif
    endtask

    initial begin
        rstn = 1'b0;
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        npc = '0;
        if_is = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_straight_line();
        test_load_use();
        test_branch_flush();
        test_mid_stall_reset();
        test_random();
        test_retire_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
